// File: rtl/demux1x2_32_stream.sv
// 1:2 word-stream demultiplexer. Select steers each word into one of two
// independent registered FIFOs, each with its own delivered-word counter.

module demux1x2_32_stream_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  input  logic                 i_push,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_pop,
  output logic                 o_full,
  output logic                 o_valid,
  output logic [WIDTH-1:0]     o_data,
  output logic [CNT_WIDTH-1:0] o_count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [AW:0]          r_occ;
  logic [WIDTH-1:0]     r_last;
  logic [CNT_WIDTH-1:0] r_count;

  // NOTE: storage is deliberately left out of reset; only entries below the
  // occupancy count are ever presented, so stale contents are never visible.
  always_ff @(posedge Clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_occ   <= '0;
      r_last  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop) begin
        r_rptr  <= r_rptr + 1'b1;
        r_last  <= r_mem[r_rptr];
        r_count <= r_count + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_full  = (r_occ == OCC_FULL);
  assign o_valid = (r_occ != '0);
  // When drained, keep showing the last delivered word rather than stale storage.
  assign o_data  = o_valid ? r_mem[r_rptr] : r_last;
  assign o_count = r_count;

endmodule

module demux1x2_32_stream #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  input  logic [WIDTH-1:0]     DataIn,
  input  logic                 Select,
  input  logic                 InValid,
  output logic                 InReady,
  output logic [WIDTH-1:0]     DataOut1,
  output logic                 OutValid1,
  input  logic                 OutReady1,
  output logic [WIDTH-1:0]     DataOut2,
  output logic                 OutValid2,
  input  logic                 OutReady2,
  output logic [CNT_WIDTH-1:0] Count1,
  output logic [CNT_WIDTH-1:0] Count2,
  output logic                 Busy
);

  logic w_full1;
  logic w_full2;
  logic w_push1;
  logic w_push2;
  logic w_pop1;
  logic w_pop2;

  // Readiness looks only at the addressed FIFO, never at the consumers.
  assign InReady = Select ? !w_full2 : !w_full1;
  assign w_push1 = InValid && !Select && !w_full1;
  assign w_push2 = InValid &&  Select && !w_full2;
  assign w_pop1  = OutValid1 && OutReady1;
  assign w_pop2  = OutValid2 && OutReady2;
  assign Busy    = OutValid1 | OutValid2;

  demux1x2_32_stream_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)
  ) u_fifo1 (
    .Clk     (Clk),
    .ResetN  (ResetN),
    .i_push  (w_push1),
    .i_data  (DataIn),
    .i_pop   (w_pop1),
    .o_full  (w_full1),
    .o_valid (OutValid1),
    .o_data  (DataOut1),
    .o_count (Count1)
  );

  demux1x2_32_stream_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)
  ) u_fifo2 (
    .Clk     (Clk),
    .ResetN  (ResetN),
    .i_push  (w_push2),
    .i_data  (DataIn),
    .i_pop   (w_pop2),
    .o_full  (w_full2),
    .o_valid (OutValid2),
    .o_data  (DataOut2),
    .o_count (Count2)
  );

endmodule

// File: tb/tb_demux1x2_32_stream.sv
// Bench for demux1x2_32_stream: directed vector table, multi-cycle corner
// sequences and a random run, all checked against a per-port queue model.

module tb_demux1x2_32_stream;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] din = '0;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        rdy1 = 1'b0;
  logic        rdy2 = 1'b0;
  logic        InReady;
  logic [31:0] DataOut1;
  logic [31:0] DataOut2;
  logic        OutValid1;
  logic        OutValid2;
  logic [15:0] Count1;
  logic [15:0] Count2;
  logic        Busy;

  demux1x2_32_stream #(.WIDTH(32), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .Clk       (clk),
    .ResetN    (rst_n),
    .DataIn    (din),
    .Select    (sel),
    .InValid   (in_valid),
    .InReady   (InReady),
    .DataOut1  (DataOut1),
    .OutValid1 (OutValid1),
    .OutReady1 (rdy1),
    .DataOut2  (DataOut2),
    .OutValid2 (OutValid2),
    .OutReady2 (rdy2),
    .Count1    (Count1),
    .Count2    (Count2),
    .Busy      (Busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [31:0] m_last1 = '0;
  logic [31:0] m_last2 = '0;
  logic [15:0] m_cnt1 = '0;
  logic [15:0] m_cnt2 = '0;
  logic        m_acc;

  typedef struct {
    logic        v, s;
    logic [31:0] d;
    logic        r1, r2;
    logic        e_rdy, e_v1;
    logic [31:0] e_d1;
    logic        e_v2;
    logic [31:0] e_d2;
    logic [15:0] e_c1, e_c2;
    logic        e_busy;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(logic v, logic s, logic [31:0] d, logic r1, logic r2,
                              logic e_rdy, logic e_v1, logic [31:0] e_d1,
                              logic e_v2, logic [31:0] e_d2,
                              logic [15:0] e_c1, logic [15:0] e_c2, logic e_busy);
    vec_t t;
    t.v = v; t.s = s; t.d = d; t.r1 = r1; t.r2 = r2;
    t.e_rdy = e_rdy; t.e_v1 = e_v1; t.e_d1 = e_d1; t.e_v2 = e_v2; t.e_d2 = e_d2;
    t.e_c1 = e_c1; t.e_c2 = e_c2; t.e_busy = e_busy;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] d,
                       input logic r1, input logic r2);
    in_valid = v; sel = s; din = d; rdy1 = r1; rdy2 = r2;
    #1;
  endtask

  // Compare against the queue model, then advance one clock and update it.
  task automatic model_step();
    logic exp_rdy, del1, del2;
    exp_rdy = sel ? (q2.size() < DEPTH) : (q1.size() < DEPTH);
    check("in_ready",  32'(InReady),   32'(exp_rdy));
    check("out_valid1", 32'(OutValid1), 32'(q1.size() != 0));
    check("data_out1", DataOut1, (q1.size() != 0) ? q1[0] : m_last1);
    check("out_valid2", 32'(OutValid2), 32'(q2.size() != 0));
    check("data_out2", DataOut2, (q2.size() != 0) ? q2[0] : m_last2);
    check("count1", 32'(Count1), 32'(m_cnt1));
    check("count2", 32'(Count2), 32'(m_cnt2));
    check("busy", 32'(Busy), 32'((q1.size() != 0) || (q2.size() != 0)));
    m_acc = in_valid && exp_rdy;
    del1  = rdy1 && (q1.size() != 0);
    del2  = rdy2 && (q2.size() != 0);
    @(posedge clk);
    if (del1) begin m_last1 = q1.pop_front(); m_cnt1++; end
    if (del2) begin m_last2 = q2.pop_front(); m_cnt2++; end
    if (m_acc) begin
      if (sel) q2.push_back(din);
      else     q1.push_back(din);
    end
    @(negedge clk);
  endtask

  task automatic cycle(input logic v, input logic s, input logic [31:0] d,
                       input logic r1, input logic r2);
    drive(v, s, d, r1, r2);
    model_step();
  endtask

  // Reset is asserted between edges so the outputs must clear without a clock.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid1", 32'(OutValid1), 32'h0);
    check("rst_valid2", 32'(OutValid2), 32'h0);
    check("rst_count1", 32'(Count1), 32'h0);
    check("rst_count2", 32'(Count2), 32'h0);
    check("rst_busy",   32'(Busy), 32'h0);
    check("rst_data1",  DataOut1, 32'h0);
    check("rst_data2",  DataOut2, 32'h0);
    q1.delete(); q2.delete();
    m_last1 = '0; m_last2 = '0; m_cnt1 = '0; m_cnt2 = '0;
    in_valid = 1'b0; sel = 1'b0; din = '0; rdy1 = 1'b0; rdy2 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic        hv, hs, pending, r1, r2;
    logic [31:0] hd;

    tbl[0]  = mk(1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        16'd0, 16'd0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        16'd0, 16'd0, 1'b1);
    tbl[2]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 32'h12345678, 16'd1, 16'd0, 1'b1);
    tbl[3]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h12345678, 16'd1, 16'd1, 1'b0);
    tbl[4]  = mk(1'b1, 1'b0, 32'h1,        1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h12345678, 16'd1, 16'd1, 1'b0);
    tbl[5]  = mk(1'b1, 1'b0, 32'h2,        1'b0, 1'b1, 1'b1, 1'b1, 32'h1,        1'b0, 32'h12345678, 16'd1, 16'd1, 1'b1);
    tbl[6]  = mk(1'b1, 1'b0, 32'h3,        1'b0, 1'b1, 1'b0, 1'b1, 32'h1,        1'b0, 32'h12345678, 16'd1, 16'd1, 1'b1);
    tbl[7]  = mk(1'b1, 1'b1, 32'h3,        1'b0, 1'b1, 1'b1, 1'b1, 32'h1,        1'b0, 32'h12345678, 16'd1, 16'd1, 1'b1);
    tbl[8]  = mk(1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'h1,        1'b1, 32'h3,        16'd1, 16'd1, 1'b1);
    tbl[9]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'h2,        1'b0, 32'h3,        16'd2, 16'd2, 1'b1);
    tbl[10] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h2,        1'b0, 32'h3,        16'd3, 16'd2, 1'b0);

    @(negedge clk);
    apply_reset();

    // Reset while FIFO 1 holds two words.
    cycle(1'b1, 1'b0, 32'hAAAA0001, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'hAAAA0002, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("pre_rst_valid1", 32'(OutValid1), 32'h1);
    apply_reset();

    // Routing and full/backpressure vectors.
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r1, tbl[i].r2);
      check($sformatf("vec%0d_in_ready", i), 32'(InReady), 32'(tbl[i].e_rdy));
      check($sformatf("vec%0d_valid1", i), 32'(OutValid1), 32'(tbl[i].e_v1));
      check($sformatf("vec%0d_data1", i), DataOut1, tbl[i].e_d1);
      check($sformatf("vec%0d_valid2", i), 32'(OutValid2), 32'(tbl[i].e_v2));
      check($sformatf("vec%0d_data2", i), DataOut2, tbl[i].e_d2);
      check($sformatf("vec%0d_count1", i), 32'(Count1), 32'(tbl[i].e_c1));
      check($sformatf("vec%0d_count2", i), 32'(Count2), 32'(tbl[i].e_c2));
      check($sformatf("vec%0d_busy", i), 32'(Busy), 32'(tbl[i].e_busy));
      model_step();
    end

    // Push and pop on port 2 every cycle with one word resident.
    apply_reset();
    cycle(1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 32'h0000_0200 + 32'(i), 1'b0, 1'b1);
      check("pp_occupancy", 32'(OutValid2), 32'h1);
    end
    drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    check("pp_count2", 32'(Count2), 32'd10);
    check("pp_head", DataOut2, 32'h0000_0209);
    model_step();

    // Counter wrap on port 1.
    apply_reset();
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 65535; i++) cycle(1'b1, 1'b0, 32'(i), 1'b1, 1'b0);
    check("wrap_ffff", 32'(Count1), 32'h0000_FFFF);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("wrap_zero", 32'(Count1), 32'h0);
    check("wrap_last", DataOut1, 32'd65535);

    // Random traffic with the producer honouring the hold rule.
    apply_reset();
    pending = 1'b0;
    hv = 1'b0; hs = 1'b0; hd = '0;
    for (int i = 0; i < 10000; i++) begin
      if (!pending) begin
        hv = ($urandom_range(0, 3) != 0);
        hs = 1'($urandom_range(0, 1));
        hd = $urandom;
      end
      r1 = ($urandom_range(0, 3) != 0);
      r2 = ($urandom_range(0, 2) != 0);
      cycle(hv, hs, hd, r1, r2);
      pending = hv && !m_acc;
    end
    for (int i = 0; i < 2 * DEPTH + 2; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("drain_valid1", 32'(OutValid1), 32'h0);
    check("drain_valid2", 32'(OutValid2), 32'h0);
    check("drain_queues", 32'(q1.size() + q2.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
